// File: rtl/local_out_port_buffer.sv
// Router local output stage: a small FIFO from the switch to the PE collector, with write/read handshake FSMs.
// Build option: define LOCAL_OUT_STATS_EN to build the saturating delivered-packet counter on PktCount.
module local_out_port_buffer #(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter int         packetwidth = 26,
  parameter int         DEPTH       = 4,
  parameter int         ADDRW       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [packetwidth-1:0] PacketIn,
  input  logic                   ReqUpStr,
  output logic                   GntUpStr,
  output logic                   UpStrFull,
  output logic [packetwidth-1:0] PacketOut,
  output logic                   ReqDnStr,
  input  logic                   GntDnStr,
  input  logic                   DnStrFull,
  output logic [15:0]            PktCount
);
  typedef enum logic {W_IDLE, W_ACK}  wstate_e;
  typedef enum logic {R_IDLE, R_SEND} rstate_e;

  localparam logic [ADDRW:0] FULL_CNT = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0] ONE_CNT  = (ADDRW+1)'(1);

  wstate_e wr_st_q, wr_st_d;
  rstate_e rd_st_q, rd_st_d;

  logic [DEPTH-1:0][packetwidth-1:0] mem_q;
  logic [ADDRW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [ADDRW:0]         count_q, count_d;
  logic                   gnt_up_q, gnt_up_d;
  logic                   req_dn_q, req_dn_d;
  logic [packetwidth-1:0] pkt_out_q, pkt_out_d;
  logic                   push, pop, full, empty, more;

  // routerID identifies the owning router; the buffer itself never inspects it.
  logic unused_cfg;
  assign unused_cfg = ^routerID;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign more   = (count_q > ONE_CNT);
  assign rd_nxt = rd_ptr_q + ADDRW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_st_q <= W_IDLE;
      rd_st_q <= R_IDLE;
    end else begin
      wr_st_q <= wr_st_d;
      rd_st_q <= rd_st_d;
    end
  end

  always_comb begin
    wr_st_d = wr_st_q;
    if (wr_st_q == W_IDLE) begin
      if (ReqUpStr && !full) wr_st_d = W_ACK;
    end else begin
      wr_st_d = W_IDLE;
    end
    rd_st_d = rd_st_q;
    if (rd_st_q == R_IDLE) begin
      if (!empty && !DnStrFull) rd_st_d = R_SEND;
    end else begin
      if (GntDnStr && !(more && !DnStrFull)) rd_st_d = R_IDLE;
    end
  end

  always_comb begin
    push      = (wr_st_q == W_IDLE) && ReqUpStr && !full;
    pop       = (rd_st_q == R_SEND) && GntDnStr;
    gnt_up_d  = push;
    req_dn_d  = req_dn_q;
    pkt_out_d = pkt_out_q;
    if (rd_st_q == R_IDLE) begin
      if (!empty && !DnStrFull) begin
        req_dn_d  = 1'b1;
        pkt_out_d = mem_q[rd_ptr_q];
      end
    end else if (GntDnStr) begin
      // Head is only retired on grant; the entry behind it is already stable in mem.
      if (more && !DnStrFull) pkt_out_d = mem_q[rd_nxt];
      else                    req_dn_d  = 1'b0;
    end
    wr_ptr_d = push ? wr_ptr_q + ADDRW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_nxt : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      gnt_up_q  <= 1'b0;
      req_dn_q  <= 1'b0;
      pkt_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      gnt_up_q  <= gnt_up_d;
      req_dn_q  <= req_dn_d;
      pkt_out_q <= pkt_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= PacketIn;
  end

  assign GntUpStr  = gnt_up_q;
  assign UpStrFull = full;
  assign ReqDnStr  = req_dn_q;
  assign PacketOut = pkt_out_q;

`ifdef LOCAL_OUT_STATS_EN
  logic [15:0] pkt_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          pkt_cnt_q <= '0;
    else if (pop && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end
  assign PktCount = pkt_cnt_q;
`else
  assign PktCount = 16'd0;
`endif

endmodule

// File: tb/tb_local_out_port_buffer.sv
// Scoreboard bench: switch and collector models drive the buffer; packets accepted are queued and checked on delivery.
module tb_local_out_port_buffer;
  localparam int PW = 26;
  localparam int DEPTH = 4;

  logic          clk, reset;
  logic [PW-1:0] PacketIn, PacketOut;
  logic          ReqUpStr, GntUpStr, UpStrFull, ReqDnStr, GntDnStr, DnStrFull;
  logic [15:0]   PktCount;

  local_out_port_buffer #(.routerID(6'b000_000), .packetwidth(PW), .DEPTH(DEPTH), .ADDRW(2)) dut (
    .clk(clk), .reset(reset), .PacketIn(PacketIn), .ReqUpStr(ReqUpStr), .GntUpStr(GntUpStr),
    .UpStrFull(UpStrFull), .PacketOut(PacketOut), .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr),
    .DnStrFull(DnStrFull), .PktCount(PktCount));

  int total = 0, bad = 0;
  int cyc = 0;
  logic [PW-1:0] tx_q[$];
  logic [PW-1:0] exp_q[$];
  int acc_n = 0, del_n = 0, b2b_n = 0;
  int gnt_cyc = 0, req_cyc = 0;
  bit holding = 0, gnt_real = 0;
  bit gnt_block = 0, rand_dly = 0, bp_rand = 0, bp_force = 0, wr_rand = 0, spur = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Switch model: presents one packet at a time, holds it until granted.
  initial begin
    ReqUpStr = 0; PacketIn = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin ReqUpStr = 0; continue; end
      if (GntUpStr) begin
        chk("gnt_without_req", {31'd0, ReqUpStr}, 1);
        exp_q.push_back(PacketIn);
        acc_n++;
        gnt_cyc = cyc;
        ReqUpStr = 0;
      end
      if (!ReqUpStr && tx_q.size() > 0 && !(wr_rand && $urandom_range(0, 2) == 0)) begin
        PacketIn = tx_q.pop_front();
        ReqUpStr = 1;
      end
    end
  end

  // Collector model and delivery monitor.
  initial begin
    bit consumed;
    bit dn_prev;
    int dly;
    logic [PW-1:0] held, e;
    GntDnStr = 0; DnStrFull = 0; dn_prev = 0; dly = 0; held = '0;
    forever begin
      @(negedge clk);
      consumed = 0;
      if (!reset) begin
        holding = 0; gnt_real = 0; GntDnStr = 0; DnStrFull = 0; dn_prev = 0;
        continue;
      end
      if (GntDnStr) begin
        GntDnStr = 0;
        if (gnt_real) begin holding = 0; del_n++; consumed = 1; end
        gnt_real = 0;
      end
      if (holding) begin
        chk("req_retracted", {31'd0, ReqDnStr}, 1);
        chk("pkt_unstable", {6'd0, PacketOut}, {6'd0, held});
      end else if (ReqDnStr) begin
        chk("req_while_dnfull", {31'd0, dn_prev}, 0);
        if (consumed) b2b_n++;
        req_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_delivery", {31'd0, ReqDnStr}, 0);
        else begin
          e = exp_q.pop_front();
          chk("pkt_data", {6'd0, PacketOut}, {6'd0, e});
        end
        held = PacketOut;
        holding = 1;
        dly = rand_dly ? $urandom_range(0, 2) : 0;
      end
`ifdef LOCAL_OUT_STATS_EN
      chk("pktcount", {16'd0, PktCount}, del_n);
`else
      chk("pktcount", {16'd0, PktCount}, 0);
`endif
      if (holding && !gnt_block) begin
        if (dly == 0) begin GntDnStr = 1; gnt_real = 1; end
        else dly--;
      end else if (!holding && spur) GntDnStr = 1;
      DnStrFull = bp_rand ? ($urandom_range(0, 3) == 0) : bp_force;
      dn_prev = DnStrFull;
    end
  end

  // Occupancy: full flag must match accepted-minus-delivered.
  initial forever begin
    @(negedge clk); #1;
    if (reset) chk("upstrfull", {31'd0, UpStrFull}, ((acc_n - del_n) == DEPTH) ? 1 : 0);
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(tx_q.size() == 0 && !ReqUpStr && exp_q.size() == 0 && !ReqDnStr && !holding && !GntUpStr)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin chk("timeout_idle", 1, 0); return; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_queued(input int target);
    int n = 0;
    while (!(acc_n >= target && holding)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin chk("timeout_queue", 1, 0); return; end
    end
  endtask

  initial begin
    int a0, d0, b0;
    logic [PW-1:0] p;
    reset = 0;
    #3;
    chk("rst_gnt", {31'd0, GntUpStr}, 0);
    chk("rst_full", {31'd0, UpStrFull}, 0);
    chk("rst_req", {31'd0, ReqDnStr}, 0);
    chk("rst_pkt", {6'd0, PacketOut}, 0);
    chk("rst_cnt", {16'd0, PktCount}, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1;

    // Single packet, minimum latency
    d0 = del_n;
    p = 26'h0A5_5A5;
    tx_q.push_back(p);
    wait_idle(100);
    chk("single_latency", req_cyc - gnt_cyc, 1);
    chk("single_delivered", del_n - d0, 1);

    // Fill beyond capacity with collector stalled
    a0 = acc_n; d0 = del_n;
    gnt_block = 1;
    for (int i = 0; i < 5; i++) tx_q.push_back(26'(32'h100 + i));
    repeat (20) @(negedge clk);
    chk("fill_accepted", acc_n - a0, 4);
    chk("fill_full", {31'd0, UpStrFull}, 1);
    chk("fill_req", {31'd0, ReqDnStr}, 1);
    gnt_block = 0;
    wait_idle(200);
    chk("fill_delivered", del_n - d0, 5);

    // Back-to-back delivery of 4 queued packets
    a0 = acc_n;
    gnt_block = 1;
    for (int i = 0; i < 4; i++) tx_q.push_back(26'($urandom()));
    wait_queued(a0 + 4);
    repeat (2) @(negedge clk);
    b0 = b2b_n; d0 = del_n;
    gnt_block = 0;
    wait_idle(200);
    chk("b2b_count", b2b_n - b0, 3);
    chk("b2b_delivered", del_n - d0, 4);

    // Backpressure holds off requests
    bp_force = 1;
    repeat (2) @(negedge clk);
    a0 = acc_n; d0 = del_n;
    tx_q.push_back(26'h3FF_FFFF); tx_q.push_back(26'h000_0001);
    repeat (15) @(negedge clk);
    chk("bp_accepted", acc_n - a0, 2);
    chk("bp_no_req", {31'd0, ReqDnStr}, 0);
    bp_force = 0;
    wait_idle(200);
    chk("bp_delivered", del_n - d0, 2);

    // Grant with no request is ignored
    d0 = del_n;
    spur = 1;
    repeat (2) @(negedge clk);
    spur = 0;
    repeat (3) @(negedge clk);
    chk("spur_no_req", {31'd0, ReqDnStr}, 0);
    chk("spur_no_del", del_n - d0, 0);

    // Random traffic: concurrent push/pop, pointer wrap, random stalls and backpressure
    rand_dly = 1; bp_rand = 1; wr_rand = 1;
    d0 = del_n;
    for (int i = 0; i < 300; i++) tx_q.push_back(26'($urandom()));
    wait_idle(20000);
    bp_rand = 0; rand_dly = 0; wr_rand = 0;
    repeat (3) @(negedge clk);
    chk("rand_delivered", del_n - d0, 300);

    // Asynchronous reset mid-transfer with 3 entries queued
    a0 = acc_n;
    gnt_block = 1;
    for (int i = 0; i < 3; i++) tx_q.push_back(26'(32'h2A0 + i));
    wait_queued(a0 + 3);
    @(posedge clk); #2;
    reset = 0;
    #1;
    chk("midrst_req", {31'd0, ReqDnStr}, 0);
    chk("midrst_pkt", {6'd0, PacketOut}, 0);
    chk("midrst_gnt", {31'd0, GntUpStr}, 0);
    chk("midrst_full", {31'd0, UpStrFull}, 0);
    chk("midrst_cnt", {16'd0, PktCount}, 0);
    @(negedge clk); #1;
    tx_q.delete(); exp_q.delete();
    acc_n = 0; del_n = 0; gnt_block = 0;
    @(negedge clk); #2;
    reset = 1;
    tx_q.push_back(26'h155_AAAA);
    wait_idle(200);
    chk("post_rst_delivered", del_n, 1);
    chk("post_rst_accepted", acc_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
